// File: rtl/bsg_adder_serial_ctrl_if.sv
// Operand/result handshake bundle for bsg_adder_serial_ctrl.
// ovf_o exists only when BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN is defined.
interface bsg_adder_serial_ctrl_if #(
  parameter int unsigned width_p = 32
);
  logic               v_i;
  logic [width_p-1:0] a_i;
  logic [width_p-1:0] b_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] s_o;
  logic               c_o;
  logic               yumi_i;
`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
  logic               ovf_o;

  modport master (
    output v_i, a_i, b_i, yumi_i,
    input  ready_o, v_o, s_o, c_o, ovf_o
  );

  modport slave (
    input  v_i, a_i, b_i, yumi_i,
    output ready_o, v_o, s_o, c_o, ovf_o
  );
`else
  modport master (
    output v_i, a_i, b_i, yumi_i,
    input  ready_o, v_o, s_o, c_o
  );

  modport slave (
    input  v_i, a_i, b_i, yumi_i,
    output ready_o, v_o, s_o, c_o
  );
`endif
endinterface

// File: rtl/bsg_adder_serial_ctrl.sv
// Chunk-serial adder: one chunk_p-bit adder reused for width_p/chunk_p cycles.
// Optional signed-overflow output enabled by BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN.
module bsg_adder_serial_ctrl #(
  parameter int unsigned width_p = 32,
  parameter int unsigned chunk_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_adder_serial_ctrl_if.slave  bus
);

  localparam int unsigned safe_chunk_lp = (chunk_p == 0) ? 1 : chunk_p;
  localparam int unsigned els_lp        = width_p / safe_chunk_lp;
  localparam int unsigned cnt_w_lp      = (els_lp > 1) ? $clog2(els_lp) : 1;

  if ((chunk_p == 0) || ((width_p % safe_chunk_lp) != 0) || (width_p == 0)) begin : g_bad_params
    $error("bsg_adder_serial_ctrl: width_p must be a nonzero multiple of nonzero chunk_p");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [width_p-1:0]   a_q, a_d;
  logic [width_p-1:0]   b_q, b_d;
  logic [width_p-1:0]   sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic                 c_q, c_d;
  logic                 ready_q, ready_d;
  logic                 v_q, v_d;

  logic [chunk_p-1:0]   chunk_s;
  logic                 chunk_c;
  logic                 last_chunk;

  assign {chunk_c, chunk_s} = {1'b0, a_q[chunk_p-1:0]}
                            + {1'b0, b_q[chunk_p-1:0]}
                            + {{chunk_p{1'b0}}, carry_q};

  assign last_chunk = (cnt_q == cnt_w_lp'(els_lp - 1));

`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // Carry into the top bit recovered from its sum bit and its two operand bits.
  assign msb_cin = a_q[chunk_p-1] ^ b_q[chunk_p-1] ^ chunk_s[chunk_p-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ready_d = ready_q;
    v_d     = v_q;
`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.v_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          carry_d = 1'b0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        a_d     = a_q >> chunk_p;
        b_d     = b_q >> chunk_p;
        // Newest chunk enters at the top; after els_lp shifts chunk 0 sits at the LSBs.
        sum_d   = sum_q >> chunk_p;
        sum_d[width_p-1 -: chunk_p] = chunk_s;
        carry_d = chunk_c;
        if (last_chunk) begin
          cnt_d   = '0;
          c_d     = chunk_c;
`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
          ovf_d   = msb_cin ^ chunk_c;
`endif
          v_d     = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end

      StDone: begin
        if (bus.yumi_i) begin
          v_d     = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        v_d     = 1'b0;
        ready_d = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      ready_q <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ready_q <= ready_d;
      v_q     <= v_d;
    end
  end

`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_o = ovf_q;
`endif

  assign bus.ready_o = ready_q;
  assign bus.v_o     = v_q;
  assign bus.s_o     = sum_q;
  assign bus.c_o     = c_q;

  a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    bus.yumi_i |-> bus.v_o)
    else $error("bsg_adder_serial_ctrl: yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_adder_serial_ctrl.sv
// Bench for bsg_adder_serial_ctrl at chunk_p = 1, 8 and 32 against an a+b model.
// Overflow checks compile in when BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN is defined.
module tb_bsg_adder_serial_ctrl;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0]   v_in, yumi_in;
  logic [W-1:0] a_in [3];
  logic [W-1:0] b_in [3];
  logic [2:0]   ready_out, v_out, c_out;
  logic [W-1:0] s_out [3];
`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
  logic [2:0]   ovf_out;
`endif
  int unsigned  els_tab [3] = '{32, 4, 1};

  bsg_adder_serial_ctrl_if #(.width_p(W)) bus0 ();
  bsg_adder_serial_ctrl_if #(.width_p(W)) bus1 ();
  bsg_adder_serial_ctrl_if #(.width_p(W)) bus2 ();

  assign bus0.v_i = v_in[0];  assign bus0.a_i = a_in[0];  assign bus0.b_i = b_in[0];
  assign bus1.v_i = v_in[1];  assign bus1.a_i = a_in[1];  assign bus1.b_i = b_in[1];
  assign bus2.v_i = v_in[2];  assign bus2.a_i = a_in[2];  assign bus2.b_i = b_in[2];
  assign bus0.yumi_i = yumi_in[0];
  assign bus1.yumi_i = yumi_in[1];
  assign bus2.yumi_i = yumi_in[2];
  assign ready_out = {bus2.ready_o, bus1.ready_o, bus0.ready_o};
  assign v_out     = {bus2.v_o, bus1.v_o, bus0.v_o};
  assign c_out     = {bus2.c_o, bus1.c_o, bus0.c_o};
  assign s_out[0]  = bus0.s_o;
  assign s_out[1]  = bus1.s_o;
  assign s_out[2]  = bus2.s_o;
`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
  assign ovf_out   = {bus2.ovf_o, bus1.ovf_o, bus0.ovf_o};
`endif

  bsg_adder_serial_ctrl #(.width_p(W), .chunk_p(1))  dut0 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus0));
  bsg_adder_serial_ctrl #(.width_p(W), .chunk_p(8))  dut1 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus1));
  bsg_adder_serial_ctrl #(.width_p(W), .chunk_p(32)) dut2 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus2));

  // Reference: the whole add at full width, plus the two's-complement overflow rule.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = ref_sum(a, b);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    int unsigned sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return '1;
      1:       return '0;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Present operands for one cycle once ready; returns in the first cycle after the accept edge.
  task automatic launch(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!ready_out[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_out[idx] !== 1'b1) begin
      errors++;
      $display("FAIL launch_ready[%0d]: ready_o=%b required 1 within 100 cycles", idx, ready_out[idx]);
    end
    v_in[idx] = 1'b1;
    a_in[idx] = a;
    b_in[idx] = b;
    @(negedge clk);
    v_in[idx] = 1'b0;
  endtask

  // lat counts cycles from the accept cycle to the first cycle with v_o=1.
  task automatic wait_v(input int idx, output int lat);
    lat = 1;
    while (!v_out[idx] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (v_out[idx] !== 1'b1) begin
      errors++;
      $display("FAIL wait_v[%0d]: v_o=%b required 1 within 200 cycles", idx, v_out[idx]);
    end
  endtask

  task automatic consume(input int idx);
    yumi_in[idx] = 1'b1;
    @(negedge clk);
    yumi_in[idx] = 1'b0;
  endtask

  task automatic check_result(input int idx, input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int lat);
    logic [W:0] exp;
    exp = ref_sum(a, b);
    checks++;
    if (lat != int'(els_tab[idx]) + 1) begin
      errors++;
      $display("FAIL %s_latency[%0d]: got %0d required %0d", name, idx, lat, els_tab[idx] + 1);
    end
    checks++;
    if (s_out[idx] !== exp[W-1:0]) begin
      errors++;
      $display("FAIL %s_sum[%0d]: got %h required %h", name, idx, s_out[idx], exp[W-1:0]);
    end
    checks++;
    if (c_out[idx] !== exp[W]) begin
      errors++;
      $display("FAIL %s_carry[%0d]: got %b required %b", name, idx, c_out[idx], exp[W]);
    end
`ifdef BSG_ADDER_SERIAL_CTRL_OVERFLOW_EN
    checks++;
    if (ovf_out[idx] !== ref_ovf(a, b)) begin
      errors++;
      $display("FAIL %s_ovf[%0d]: got %b required %b", name, idx, ovf_out[idx], ref_ovf(a, b));
    end
`endif
  endtask

  task automatic test_reset();
    int lat;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ready_out[i], v_out[i], c_out[i]} !== 3'b100 || s_out[i] !== '0) begin
        errors++;
        $display("FAIL reset_state[%0d]: ready/v/c=%b%b%b s=%h required 100 s=0",
                 i, ready_out[i], v_out[i], c_out[i], s_out[i]);
      end
    end
    launch(1, 32'h0000_0005, 32'h0000_0006);
    wait_v(1, lat);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ready_out[1], v_out[1], c_out[1]} !== 3'b100 || s_out[1] !== '0) begin
      errors++;
      $display("FAIL async_reset: ready/v/c=%b%b%b s=%h required 100 s=0",
               ready_out[1], v_out[1], c_out[1], s_out[1]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_add();
    int lat;
    launch(1, 32'h0000_0003, 32'h0000_0004);
    wait_v(1, lat);
    check_result(1, "small_add", 32'h0000_0003, 32'h0000_0004, lat);
    consume(1);
    checks++;
    if (v_out[1] !== 1'b0 || ready_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL after_yumi: v/ready=%b%b required 01", v_out[1], ready_out[1]);
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    launch(1, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_v(1, lat);
    check_result(1, "ripple", 32'hFFFF_FFFF, 32'h0000_0001, lat);
    consume(1);
    launch(1, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_v(1, lat);
    check_result(1, "signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, lat);
    consume(1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] a1, b1, a2, b2, held;
    a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
    launch(1, a1, b1);
    wait_v(1, lat);
    check_result(1, "bp_first", a1, b1, lat);
    held = s_out[1];
    v_in[1] = 1'b1;
    a_in[1] = a2;
    b_in[1] = b2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (s_out[1] !== held || ready_out[1] !== 1'b0 || v_out[1] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: s=%h ready=%b v=%b required s=%h ready=0 v=1",
                 i, s_out[1], ready_out[1], v_out[1], held);
      end
    end
    // Taking the result in the first DONE cycle also exercises the els_lp+2 throughput.
    consume(1);
    checks++;
    if (ready_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_yumi: got %b required 1", ready_out[1]);
    end
    @(negedge clk);
    v_in[1] = 1'b0;
    wait_v(1, lat);
    check_result(1, "bp_second", a2, b2, lat);
    consume(1);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] a1, b1, a2, b2;
    a1 = rnd_operand(); b1 = rnd_operand(); a2 = rnd_operand(); b2 = rnd_operand();
    launch(1, a1, b1);
    wait_v(1, lat);
    check_result(1, "b2b_first", a1, b1, lat);
    v_in[1] = 1'b1;
    a_in[1] = a2;
    b_in[1] = b2;
    consume(1);
    checks++;
    if (ready_out[1] !== 1'b1 || lat + 1 != int'(els_tab[1]) + 2) begin
      errors++;
      $display("FAIL b2b_period: ready=%b period=%0d required ready=1 period=%0d",
               ready_out[1], lat + 1, els_tab[1] + 2);
    end
    @(negedge clk);
    v_in[1] = 1'b0;
    wait_v(1, lat);
    check_result(1, "b2b_second", a2, b2, lat);
    consume(1);
  endtask

  task automatic test_reset_busy();
    int lat;
    launch(1, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (v_out[1] !== 1'b0 || ready_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: v/ready=%b%b required 01", v_out[1], ready_out[1]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (v_out[1] !== 1'b0) begin
        errors++;
        $display("FAIL stale_v cycle %0d: got %b required 0", i, v_out[1]);
      end
    end
    launch(1, 32'h0000_0010, 32'h0000_0020);
    wait_v(1, lat);
    check_result(1, "after_reset", 32'h0000_0010, 32'h0000_0020, lat);
    consume(1);
  endtask

  task automatic test_random(input int idx, input int n_ops);
    int lat;
    logic [W-1:0] a, b, held;
    for (int k = 0; k < n_ops; k++) begin
      a = rnd_operand();
      b = rnd_operand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(idx, a, b);
      wait_v(idx, lat);
      check_result(idx, "random", a, b, lat);
      held = s_out[idx];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (s_out[idx] !== held || v_out[idx] !== 1'b1) begin
        errors++;
        $display("FAIL random_hold[%0d]: s=%h v=%b required s=%h v=1", idx, s_out[idx],
                 v_out[idx], held);
      end
      consume(idx);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    v_in    = '0;
    yumi_in = '0;
    for (int i = 0; i < 3; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    test_reset();
    test_small_add();
    test_carry_ripple();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    test_random(0, 250);
    test_random(1, 600);
    test_random(2, 800);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
